// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the T-flip-flop counter controller:
// FSM state encodings and direction constants.
package tff_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } ctrlState_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage : tff_ctrl_pkg

// File: rtl/tff_cell.sv
// Single T-type storage cell: toggles on a rising CLK edge when T is high,
// asynchronously cleared to 0 while RST is low.
module tff_cell (
   input  logic CLK,
   input  logic RST,
   input  logic T,
   output logic Q,
   output logic Qn
);

   logic qReg;

   // Toggle storage with asynchronous active-low clear
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         qReg <= 1'b0;
      end else begin
         qReg <= qReg ^ T;
      end
   end

   assign Q  = qReg;
   assign Qn = ~qReg;

endmodule : tff_cell

// File: rtl/tff_count_ctrl.sv
// Sequencing controller that drives a bank of T cells as a programmable
// up/down counter: load START_VAL, step on EN, stop on the latched LIMIT.
module tff_count_ctrl
   import tff_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ABORT,
   input  logic             EN,
   input  logic             DIR,
   input  logic [WIDTH-1:0] START_VAL,
   input  logic [WIDTH-1:0] LIMIT,
   output logic [WIDTH-1:0] COUNT,
   output logic [WIDTH-1:0] T_VEC,
   output logic             BUSY,
   output logic             DONE
);

   ctrlState_t       stateReg;
   ctrlState_t       stateNext;
   logic             dirReg;
   logic [WIDTH-1:0] limitReg;
   logic [WIDTH-1:0] countQ;
   logic [WIDTH-1:0] countQn;
   logic [WIDTH-1:0] stepVal;
   logic [WIDTH-1:0] countNext;
   logic [WIDTH-1:0] tVec;

   for (genvar i = 0; i < WIDTH; i++) begin : gCell
      tff_cell uCell (
         .CLK (CLK),
         .RST (RST),
         .T   (tVec[i]),
         .Q   (countQ[i]),
         .Qn  (countQn[i])
      );
   end

   // The down step uses the complement outputs: cur-1 == ~(~cur + 1)
   assign stepVal = (dirReg == DIR_UP) ? (countQ + WIDTH'(1))
                                       : ~(countQn + WIDTH'(1));

   // State, latched direction and latched limit
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stateReg <= ST_IDLE;
         dirReg   <= DIR_DN;
         limitReg <= '0;
      end else begin
         stateReg <= stateNext;
         if ((stateReg == ST_IDLE) && START) begin
            dirReg   <= DIR;
            limitReg <= LIMIT;
         end else begin
            dirReg   <= dirReg;
            limitReg <= limitReg;
         end
      end
   end

   // Next state and next count; the toggle vector is derived from the latter
   always_comb begin
      stateNext = stateReg;
      countNext = countQ;
      case (stateReg)
         ST_IDLE: begin
            if (START) begin
               countNext = START_VAL;
               stateNext = (START_VAL == LIMIT) ? ST_DONE : ST_RUN;
            end else begin
               stateNext = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (ABORT) begin
               stateNext = ST_IDLE;
            end else if (EN) begin
               countNext = stepVal;
               stateNext = (stepVal == limitReg) ? ST_DONE : ST_RUN;
            end else begin
               stateNext = ST_RUN;
            end
         end
         ST_DONE: begin
            stateNext = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

   assign tVec = countQ ^ countNext;

   // Output decode from the state register
   always_comb begin
      BUSY = 1'b0;
      DONE = 1'b0;
      case (stateReg)
         ST_IDLE: begin
            BUSY = 1'b0;
            DONE = 1'b0;
         end
         ST_RUN: begin
            BUSY = 1'b1;
            DONE = 1'b0;
         end
         ST_DONE: begin
            BUSY = 1'b1;
            DONE = 1'b1;
         end
         default: begin
            BUSY = 1'b0;
            DONE = 1'b0;
         end
      endcase
   end

   assign COUNT = countQ;
   assign T_VEC = tVec;

endmodule : tff_count_ctrl

// File: tb/tb_tff_count_ctrl.sv
// Directed self-checking bench for tff_count_ctrl (WIDTH = 4).
module tb_tff_count_ctrl;

   logic       CLK;
   logic       RST;
   logic       START;
   logic       ABORT;
   logic       EN;
   logic       DIR;
   logic [3:0] START_VAL;
   logic [3:0] LIMIT;
   logic [3:0] COUNT;
   logic [3:0] T_VEC;
   logic       BUSY;
   logic       DONE;

   int checkCount;
   int passCount;

   tff_count_ctrl #(.WIDTH(4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .ABORT     (ABORT),
      .EN        (EN),
      .DIR       (DIR),
      .START_VAL (START_VAL),
      .LIMIT     (LIMIT),
      .COUNT     (COUNT),
      .T_VEC     (T_VEC),
      .BUSY      (BUSY),
      .DONE      (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs and checks happen 1 time unit after the edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkState(input string tag, input logic [3:0] cnt,
                             input logic busy, input logic done);
      checkVal({tag, ".count"}, {4'h0, COUNT}, {4'h0, cnt});
      checkVal({tag, ".busy"},  {7'h0, BUSY},  {7'h0, busy});
      checkVal({tag, ".done"},  {7'h0, DONE},  {7'h0, done});
   endtask

   task automatic startRun(input logic [3:0] sv, input logic [3:0] lim, input logic dir);
      START_VAL = sv;
      LIMIT     = lim;
      DIR       = dir;
      START     = 1'b1;
      tick();
      START     = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      RST = 1'b0; START = 1'b0; ABORT = 1'b0; EN = 1'b0; DIR = 1'b1;
      START_VAL = 4'h0; LIMIT = 4'h0;
      #12;
      checkState("reset", 4'h0, 1'b0, 1'b0);
      checkVal("reset.tvec", {4'h0, T_VEC}, 8'h00);
      RST = 1'b1;
      tick();
      checkState("idle", 4'h0, 1'b0, 1'b0);

      // Up run 2 -> 5
      EN = 1'b1;
      startRun(4'd2, 4'd5, 1'b1);
      checkState("up.s0", 4'd2, 1'b1, 1'b0);
      checkVal("up.t0", {4'h0, T_VEC}, 8'h01);
      tick();
      checkState("up.s1", 4'd3, 1'b1, 1'b0);
      checkVal("up.t1", {4'h0, T_VEC}, 8'h07);
      tick();
      checkState("up.s2", 4'd4, 1'b1, 1'b0);
      checkVal("up.t2", {4'h0, T_VEC}, 8'h01);
      tick();
      checkState("up.done", 4'd5, 1'b1, 1'b1);
      checkVal("up.tdone", {4'h0, T_VEC}, 8'h00);
      tick();
      checkState("up.idle", 4'd5, 1'b0, 1'b0);

      // Back-to-back: down wrap 1 -> 14 started in the first IDLE cycle
      startRun(4'd1, 4'd14, 1'b0);
      checkState("dn.s0", 4'd1, 1'b1, 1'b0);
      LIMIT = 4'd3; DIR = 1'b1; START = 1'b1;   // must not disturb the run
      checkVal("dn.t0", {4'h0, T_VEC}, 8'h01);
      tick();
      START = 1'b0;
      checkState("dn.s1", 4'd0, 1'b1, 1'b0);
      checkVal("dn.t1", {4'h0, T_VEC}, 8'h0F);
      tick();
      checkState("dn.s2", 4'd15, 1'b1, 1'b0);
      tick();
      checkState("dn.done", 4'd14, 1'b1, 1'b1);
      tick();
      checkState("dn.idle", 4'd14, 1'b0, 1'b0);

      // Up run with limit behind start: 14,15,0,1
      startRun(4'd14, 4'd1, 1'b1);
      tick();
      checkVal("wrap.c15", {4'h0, COUNT}, 8'h0F);
      checkVal("wrap.t15", {4'h0, T_VEC}, 8'h0F);
      tick();
      tick();
      checkState("wrap.done", 4'd1, 1'b1, 1'b1);
      tick();

      // EN pattern 1,0,0,1,1 from 3 toward 6
      EN = 1'b1;
      startRun(4'd3, 4'd6, 1'b1);
      tick();
      checkState("en.s1", 4'd4, 1'b1, 1'b0);
      EN = 1'b0;
      #1 checkVal("en.thold", {4'h0, T_VEC}, 8'h00);
      tick();
      checkState("en.h1", 4'd4, 1'b1, 1'b0);
      tick();
      checkState("en.h2", 4'd4, 1'b1, 1'b0);
      EN = 1'b1;
      tick();
      checkState("en.s3", 4'd5, 1'b1, 1'b0);
      tick();
      checkState("en.done", 4'd6, 1'b1, 1'b1);
      tick();

      // Abort at 7 during run 5 -> 12
      startRun(4'd5, 4'd12, 1'b1);
      tick();
      tick();
      checkVal("ab.c7", {4'h0, COUNT}, 8'h07);
      ABORT = 1'b1;
      #1 checkVal("ab.t", {4'h0, T_VEC}, 8'h00);
      tick();
      ABORT = 1'b0;
      checkState("ab.idle", 4'd7, 1'b0, 1'b0);
      tick();
      checkState("ab.idle2", 4'd7, 1'b0, 1'b0);

      // Minimum run 9 == 9, START pulsed during DONE is ignored
      startRun(4'd9, 4'd9, 1'b1);
      checkState("min.done", 4'd9, 1'b1, 1'b1);
      START = 1'b1; ABORT = 1'b1;
      tick();
      START = 1'b0; ABORT = 1'b0;
      checkState("min.idle", 4'd9, 1'b0, 1'b0);
      tick();
      checkState("min.idle2", 4'd9, 1'b0, 1'b0);

      // Asynchronous reset mid-run
      EN = 1'b1;
      startRun(4'd0, 4'd10, 1'b1);
      tick();
      tick();
      checkVal("rst.pre", {4'h0, COUNT}, 8'h02);
      #2 RST = 1'b0;
      #1 checkState("rst.async", 4'd0, 1'b0, 1'b0);
      tick();
      RST = 1'b1;
      EN  = 1'b0;
      tick();
      checkState("rst.idle", 4'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule : tb_tff_count_ctrl

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of toggle flip-flops. It owns `WIDTH` T-type storage cells and drives their per-bit toggle inputs so the bank behaves as a programmable up/down counter. Each run starts from `START_VAL`, steps once per enabled cycle, and stops on `LIMIT`, with wrap-around modulo 2^WIDTH. It sits between a host that issues start/abort commands and the T-flip-flop datapath. The controller never writes the cells directly; it only generates the toggle vector.

## Interface
Parameters:
- `WIDTH`, default 4: number of T cells and width of all count buses.

Ports:
- `CLK`  in  1: single clock; all state updates on its rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `START`  in  1: begin a run; sampled only in IDLE.
- `ABORT`  in  1: cancel an active run.
- `EN`  in  1: step enable during RUN.
- `DIR`  in  1: direction, latched at START; 1 = up, 0 = down.
- `START_VAL`  in  WIDTH: initial count, loaded at START.
- `LIMIT`  in  WIDTH: terminal count, latched at START.
- `COUNT`  out  WIDTH: current T-cell bank contents (Q outputs).
- `T_VEC`  out  WIDTH: combinational toggle vector applied at the next edge.
- `BUSY`  out  1: high when the state is not IDLE.
- `DONE`  out  1: one-cycle pulse while in the DONE state.

## Operation
- The only storage is the cell bank plus the state, latched `DIR`, and latched `LIMIT`.
- Every count change is made as `T_VEC = COUNT ^ next_count`. `T_VEC` is 0 whenever the count holds.
- States:
  - IDLE: `T_VEC` is 0.
    - `START`=1 → `COUNT` := `START_VAL`; `DIR` and `LIMIT` are latched.
    - If `START_VAL` == `LIMIT`, next state is DONE; otherwise next state is RUN.
  - RUN:
    - `ABORT`=1 → IDLE. `COUNT` holds and `DONE` is not pulsed. `ABORT` has priority over `EN`.
    - Else `EN`=1 → `COUNT` := `COUNT`+1 (up) or `COUNT`−1 (down), modulo 2^WIDTH. If the new value equals the latched `LIMIT`, next state is DONE.
    - Else (`EN`=0) → hold, `T_VEC`=0.
  - DONE: `DONE`=1 for exactly one cycle, then → IDLE. `COUNT` holds at `LIMIT`. `ABORT` is ignored in this state.
- `START` in RUN or DONE is ignored and not queued.
- `ABORT` in IDLE has no effect.
- `LIMIT` and `DIR` changes after START do not affect the current run.
- Wrap-around: up from 2^WIDTH−1 goes to 0; down from 0 goes to 2^WIDTH−1. A run whose limit is "behind" the start value wraps until it reaches the limit.

## Timing
- Reset values: `COUNT`=0, `T_VEC`=0, `BUSY`=0, `DONE`=0, state = IDLE.
- Reset asserted mid-run forces reset values immediately, without waiting for a clock edge.
- START latency: `COUNT` shows `START_VAL` and `BUSY`=1 one cycle after the edge that samples `START`.
- Step latency: one `EN` cycle per count step.
- `DONE` pulses in the cycle after the edge where `COUNT` becomes `LIMIT`. `BUSY` drops one cycle after that.
- Minimum run (`START_VAL` == `LIMIT`): `BUSY` high for 1 cycle, with `DONE` high in that same cycle.
- Back-to-back runs: `START` is accepted in the first IDLE cycle after DONE.
- Run length in up mode is (`LIMIT` − `START_VAL`) mod 2^WIDTH enabled cycles, then 1 DONE cycle.

## Structure
- Shared package `tff_ctrl_pkg`: state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the direction constants (`DIR_UP`=1, `DIR_DN`=0).
- One sub-module: `tff_cell`.
  - One T flip-flop with async active-low reset to 0 and outputs `Q`/`Qn`.
  - Instantiated `WIDTH` times in a generate loop.
  - `COUNT` is the concatenated `Q` outputs.
- Next-count adder/subtractor, `T_VEC` XOR, and FSM in the top module.

## Test plan
- Up run, `WIDTH`=4, `START_VAL`=2, `LIMIT`=5, `EN`=1 → `COUNT` 2,3,4,5; `DONE` high exactly one cycle with `COUNT`=5; `BUSY` low the next cycle; `T_VEC` 1, 7, 1 on the three steps.
- Down wrap, `START_VAL`=1, `LIMIT`=14, `DIR`=0 → `COUNT` 1,0,15,14, then `DONE`; `T_VEC`=4'hF on the 0→15 step.
- `EN` toggled 1,0,0,1,1 from 3 toward 6 → `COUNT` 4,4,4,5,6; `T_VEC`=0 on hold cycles; `DONE` after 6.
- `ABORT` asserted with `EN` at `COUNT`=7 (run 5→12) → `COUNT` stays 7, no `DONE` pulse, `BUSY`=0 next cycle; a new `START` is accepted afterwards.
- `START_VAL`=`LIMIT`=9 → `BUSY` and `DONE` high for one cycle, `COUNT`=9. A second `START` pulsed during a run is ignored, with no change to `LIMIT`.
- `RST` low asynchronously mid-run between edges → `COUNT`=0 and `BUSY`=0 immediately; after release, state is IDLE.
